// File: rtl/wr_demux.sv
// Write demultiplexer into a flat register store with per-entry valid flags,
// registered write acknowledge and out-of-range error flag.
module wr_demux #(
   parameter int WIDTH    = 5,
   parameter int WID      = 32,
   parameter int DEPTH    = 1 << WIDTH,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   write_en_i,
   input  logic [WIDTH-1:0]       index_i,
   input  logic [WID-1:0]         data_i,
   input  logic                   clear_en_i,
   input  logic [WIDTH-1:0]       clear_index_i,
   output logic [WID*DEPTH-1:0]   data_o,
   output logic [DEPTH-1:0]       valid_o,
   output logic                   write_ack_o,
   output logic                   err_o
);

   localparam logic [DEPTH-1:0] VALID_RST = DEPTH'((ZERO_REG != 0) ? 1'b1 : 1'b0);

   logic                      w_wr_in_range;
   logic                      w_clr_in_range;
   logic                      w_wr_ok;
   logic                      w_clr_ok;
   logic [DEPTH-1:0]          w_wr_sel;
   logic [DEPTH-1:0]          w_clr_sel;
   logic [DEPTH-1:0]          w_valid_nxt;

   logic [DEPTH-1:0][WID-1:0] r_data;
   logic [DEPTH-1:0]          r_valid;
   logic                      r_ack;
   logic                      r_err;

   assign w_wr_in_range  = (32'(index_i) < 32'(DEPTH));
   assign w_clr_in_range = (32'(clear_index_i) < 32'(DEPTH));
   assign w_wr_ok        = write_en_i && w_wr_in_range;
   assign w_clr_ok       = clear_en_i && w_clr_in_range;

   // Entry decode and next valid flags; a write overrides a clear to the same entry.
   always_comb begin
      w_wr_sel    = '0;
      w_clr_sel   = '0;
      w_valid_nxt = r_valid;
      for (int i = 0; i < DEPTH; i++) begin
         if ((ZERO_REG != 0) && (i == 0)) begin
            w_valid_nxt[i] = 1'b1;
         end else begin
            w_wr_sel[i]    = w_wr_ok  && (32'(index_i) == 32'(i));
            w_clr_sel[i]   = w_clr_ok && (32'(clear_index_i) == 32'(i));
            w_valid_nxt[i] = w_wr_sel[i] | (r_valid[i] & ~w_clr_sel[i]);
         end
      end
   end

   // Storage, valid flags and the one-cycle ack/error pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data  <= '0;
         r_valid <= VALID_RST;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_sel[i]) begin
               r_data[i] <= data_i;
            end
         end
         r_valid <= w_valid_nxt;
         r_ack   <= w_wr_ok;
         r_err   <= write_en_i && !w_wr_in_range;
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign write_ack_o = r_ack;
   assign err_o       = r_err;

endmodule
